// File: rtl/fft_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared FFT constants, sample type and loader state encoding.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int FFT_LOG2N = 10;
    localparam int FFT_N     = 1 << FFT_LOG2N;
    localparam int SAMPLE_W  = 32;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FULL  = 2'd2
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_input_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_input_loader_if
// Brief    : FIFO, RAM-write and sequencer handshake bundle of the input loader.
// Revision : 1.0
// ============================================================================
interface fft_input_loader_if #(
    parameter int LOG2N    = fft_pkg::FFT_LOG2N,
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
    parameter int CNT_W    = 11
);
    logic                frame_start;
    logic                loadExternal;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic                fifo_ren;
    logic                ram_wen;
    logic [LOG2N-1:0]    ram_waddr;
    logic [SAMPLE_W-1:0] ram_wdata;
    logic                startLoadingRam;
    logic                inFifoEmpty;
    logic                loadExternalDone;

    modport master (
        input  frame_start, loadExternal, fifo_empty, fifo_count, fifo_rdata,
        output fifo_ren, ram_wen, ram_waddr, ram_wdata,
               startLoadingRam, inFifoEmpty, loadExternalDone
    );

    modport slave (
        output frame_start, loadExternal, fifo_empty, fifo_count, fifo_rdata,
        input  fifo_ren, ram_wen, ram_waddr, ram_wdata,
               startLoadingRam, inFifoEmpty, loadExternalDone
    );
endinterface
`default_nettype wire

// File: rtl/fft_input_loader_bit_reverse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bit_reverse
// Brief    : Combinational bit-order reversal of a W-bit address.
// Revision : 1.0
// ============================================================================
module bit_reverse #(
    parameter int W = 10
) (
    input  wire logic [W-1:0] in,
    output logic      [W-1:0] out
);
    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            assign out[i] = in[W-1-i];
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/fft_input_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_input_loader
// Brief    : Drains the input sample FIFO into the FFT RAM at bit-reversed
//            addresses and drives the sequencer load handshake.
// Revision : 1.0
// ============================================================================
module fft_input_loader #(
    parameter int LOG2N    = fft_pkg::FFT_LOG2N,
    parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
    parameter int CNT_W    = 11,
    parameter int BURST    = 16,
    parameter bit BITREV   = 1'b1
) (
    input wire logic           clk,
    input wire logic           rst,
    fft_input_loader_if.master bus
);
    import fft_pkg::*;

    localparam int             CW      = LOG2N + 1;
    localparam logic [LOG2N:0] c_N     = {1'b1, {LOG2N{1'b0}}};
    localparam logic [LOG2N:0] c_LAST  = c_N - CW'(1);
    localparam logic [LOG2N:0] c_BURST = CW'(BURST);

    loader_state_t       r_state;
    loader_state_t       w_stateNext;
    logic [LOG2N:0]      r_issued;
    logic [LOG2N:0]      r_written;
    logic                r_rdPending;
    logic                r_done;
    logic                w_ren;
    logic                w_armed;
    logic                w_issueRoom;
    logic [LOG2N:0]      w_remain;
    logic [CNT_W-1:0]    w_countRaw;
    logic [LOG2N:0]      w_count;
    logic [LOG2N-1:0]    w_addr;
    logic [SAMPLE_W-1:0] w_wdata;

    assign w_armed     = (r_state == ARMED);
    assign w_issueRoom = (r_issued < c_N);
    assign w_remain    = c_N - r_issued;
    assign w_countRaw  = bus.fifo_count;
    assign w_count     = CW'(w_countRaw);
    assign w_wdata     = bus.fifo_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A frame_start cycle never issues a read, so the clear cannot race a pop.
    always_comb begin
        w_stateNext = r_state;
        w_ren       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.frame_start) w_stateNext = ARMED;
            end
            ARMED: begin
                if (!bus.frame_start && (r_written == c_N)) w_stateNext = FULL;
                w_ren = bus.loadExternal & ~bus.fifo_empty & w_issueRoom & ~bus.frame_start;
            end
            FULL: begin
                if (bus.frame_start) w_stateNext = ARMED;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // The write of a read in flight at frame_start still lands but is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued    <= '0;
            r_written   <= '0;
            r_rdPending <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rdPending <= w_ren;
            if (bus.frame_start) begin
                r_issued  <= '0;
                r_written <= '0;
                r_done    <= 1'b0;
            end else begin
                if (w_ren) r_issued <= r_issued + 1'b1;
                if (r_rdPending) begin
                    r_written <= r_written + 1'b1;
                    if (r_written == c_LAST) r_done <= 1'b1;
                end
            end
        end
    end

    generate
        if (BITREV) begin : g_bitrev
            bit_reverse #(.W(LOG2N)) u_bitRev (
                .in  (r_written[LOG2N-1:0]),
                .out (w_addr)
            );
        end else begin : g_natural
            assign w_addr = r_written[LOG2N-1:0];
        end
    endgenerate

    assign bus.fifo_ren         = w_ren;
    assign bus.ram_wen          = r_rdPending;
    assign bus.ram_waddr        = w_addr;
    assign bus.ram_wdata        = w_wdata;
    assign bus.loadExternalDone = r_done;
    assign bus.startLoadingRam  = w_armed & ~bus.loadExternal & w_issueRoom &
                                  ((w_count >= c_BURST) |
                                   ((w_count != '0) & (w_count >= w_remain)));
    assign bus.inFifoEmpty      = (w_armed & bus.fifo_empty & ~r_rdPending) |
                                  ((r_issued == c_N) & ~r_rdPending);

endmodule
`default_nettype wire

// File: tb/tb_fft_input_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft_input_loader
// Brief    : Randomised bench with a frame-level loader model and FIFO/sequencer models.
// Revision : 1.0
// ============================================================================
module tb_fft_input_loader;
    import fft_pkg::*;

    localparam int LOG2N = 10;
    localparam int N     = 1 << LOG2N;
    localparam int SW    = 32;
    localparam int CW    = 11;
    localparam int BURST = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_input_loader_if #(.LOG2N(LOG2N), .SAMPLE_W(SW), .CNT_W(CW)) bus ();
    fft_input_loader_if #(.LOG2N(LOG2N), .SAMPLE_W(SW), .CNT_W(CW)) busN ();

    fft_input_loader #(.LOG2N(LOG2N), .SAMPLE_W(SW), .CNT_W(CW), .BURST(BURST), .BITREV(1'b1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    fft_input_loader #(.LOG2N(LOG2N), .SAMPLE_W(SW), .CNT_W(CW), .BURST(BURST), .BITREV(1'b0))
        dutN (.clk(clk), .rst(rst), .bus(busN));

    assign busN.frame_start  = bus.frame_start;
    assign busN.loadExternal = bus.loadExternal;
    assign busN.fifo_empty   = bus.fifo_empty;
    assign busN.fifo_count   = bus.fifo_count;
    assign busN.fifo_rdata   = bus.fifo_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // environment: FIFO contents, frame contents, DUT write log, RAM image
    logic [31:0]      fifoQ[$];
    logic [31:0]      frameSamples[$];
    logic [31:0]      wData[$];
    logic [LOG2N-1:0] wAddr[$];
    logic [LOG2N-1:0] wAddrN[$];
    logic [31:0]      ramImg[N];
    logic [31:0]      popData = '0;
    int renCount = 0, firstRenCyc = -1, lastRenCyc = 0, lastWenCyc = 0, doneRiseCyc = 0;
    bit prevDone = 0, obsSlr = 0, obsIfe = 0, obsDone = 0;
    bit seqMode = 0, seqDrop = 0;
    int trickleLeft = 0, trickleP = 0;

    // reference model of the loader, frame level
    int mIssued = 0, mWritten = 0, mPhase = 0;   // phase: 0 idle, 1 loading, 2 frame full
    bit mPending = 0, mDone = 0;
    logic [31:0] mData = '0;
    bit eRen, eWen, eSlr, eIfe, fs, le, emp;
    int cnt, nextPhase;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int brev(input int v);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) if (v[b]) r |= 1 << (LOG2N - 1 - b);
        return r;
    endfunction

    // compare process: late in every cycle, well clear of the rising edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                mIssued = 0; mWritten = 0; mPending = 0; mDone = 0; mPhase = 0;
            end
            fs  = bus.frame_start;
            le  = bus.loadExternal;
            emp = bus.fifo_empty;
            cnt = int'(bus.fifo_count);
            eRen = !rst && mPhase == 1 && le && !emp && mIssued < N && !fs;
            eWen = mPending;
            eSlr = mPhase == 1 && !le && mIssued < N &&
                   (cnt >= BURST || (cnt != 0 && cnt >= N - mIssued));
            eIfe = (mPhase == 1 && emp && !mPending) || (mIssued == N && !mPending);

            chk("fifo_ren", bus.fifo_ren, eRen);
            chk("ram_wen", bus.ram_wen, eWen);
            chk("startLoadingRam", bus.startLoadingRam, eSlr);
            chk("inFifoEmpty", bus.inFifoEmpty, eIfe);
            chk("loadExternalDone", bus.loadExternalDone, mDone);
            chk("nat_ram_wen", busN.ram_wen, eWen);
            if (eWen) begin
                chk("ram_waddr", bus.ram_waddr, brev(mWritten % N));
                chk("ram_wdata", bus.ram_wdata, mData);
                chk("nat_ram_waddr", busN.ram_waddr, mWritten % N);
            end

            if (bus.ram_wen) begin
                wAddr.push_back(bus.ram_waddr);
                wAddrN.push_back(busN.ram_waddr);
                wData.push_back(bus.ram_wdata);
                ramImg[bus.ram_waddr] = bus.ram_wdata;
                lastWenCyc = cyc;
            end
            if (bus.loadExternalDone && !prevDone) doneRiseCyc = cyc;
            prevDone = bus.loadExternalDone;
            if (bus.fifo_ren) begin
                renCount++;
                if (firstRenCyc < 0) firstRenCyc = cyc;
                lastRenCyc = cyc;
            end
            obsSlr  = bus.startLoadingRam;
            obsIfe  = bus.inFifoEmpty;
            obsDone = bus.loadExternalDone;

            if (eRen && fifoQ.size() > 0) mData = fifoQ[0];
            if (bus.fifo_ren && fifoQ.size() > 0) popData = fifoQ.pop_front();

            if (!rst) begin
                nextPhase = fs ? 1 : ((mPhase == 1 && mWritten == N) ? 2 : mPhase);
                if (fs) begin
                    mIssued = 0; mWritten = 0; mDone = 0;
                end else begin
                    if (eRen) mIssued++;
                    if (mPending) begin
                        mWritten++;
                        if (mWritten == N) mDone = 1;
                    end
                end
                mPending = eRen;
                mPhase   = nextPhase;
            end
        end
    end

    task automatic drive_fifo();
        bus.fifo_empty = (fifoQ.size() == 0);
        bus.fifo_count = CW'(fifoQ.size());
        bus.fifo_rdata = popData;
    endtask

    task automatic push_frame(input logic [31:0] v);
        fifoQ.push_back(v);
        frameSamples.push_back(v);
        drive_fifo();
    endtask

    // one cycle: FIFO outputs, sequencer grant model, random trickle
    task automatic step();
        @(negedge clk);
        bus.frame_start = 1'b0;
        if (seqMode) begin
            if (bus.loadExternal && (obsIfe || (seqDrop && $urandom_range(0, 9) == 0)))
                bus.loadExternal = 1'b0;
            else if (!bus.loadExternal && obsSlr)
                bus.loadExternal = 1'b1;
        end
        if (trickleLeft > 0 && $urandom_range(0, 99) < trickleP) begin
            push_frame($urandom);
            trickleLeft--;
        end
        drive_fifo();
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        frameSamples.delete();
        renCount    = 0;
        firstRenCyc = -1;
    endtask

    task automatic wait_done(input int budget, input string name);
        step();
        step();
        for (int i = 0; i < budget && !obsDone; i++) step();
        chk(name, obsDone, 1);
    endtask

    task automatic check_ram(input string name);
        int mism = 0;
        for (int k = 0; k < N; k++)
            if (k >= frameSamples.size() || ramImg[brev(k)] !== frameSamples[k]) mism++;
        chk(name, mism, 0);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int mark;
        cplx_t s;
        bus.frame_start  = 1'b0;
        bus.loadExternal = 1'b0;
        drive_fifo();

        // reset
        rst = 1'b1;
        repeat (3) step();
        chk("reset_outputs", {bus.fifo_ren, bus.ram_wen, bus.startLoadingRam,
                              bus.inFifoEmpty, bus.loadExternalDone}, 5'b0);
        rst = 1'b0;
        repeat (2) step();

        // steady load, FIFO preloaded with value = index
        step();
        pulse_fs();
        bus.loadExternal = 1'b1;
        mark = wAddr.size();
        for (int i = 0; i < N; i++) push_frame(32'(i));
        wait_done(3000, "steady_done");
        chk("steady_ren_count", renCount, N);
        chk("steady_ren_consecutive", lastRenCyc - firstRenCyc, N - 1);
        chk("steady_w1_addr", wAddr[mark], 10'h000);
        chk("steady_w1_data", wData[mark], 32'd0);
        chk("steady_w2_addr", wAddr[mark + 1], 10'h200);
        chk("steady_w2_data", wData[mark + 1], 32'd1);
        chk("steady_w3_addr", wAddr[mark + 2], 10'h100);
        chk("steady_w3_data", wData[mark + 2], 32'd2);
        chk("steady_last_addr", wAddr[mark + N - 1], 10'h3FF);
        chk("steady_done_latency", doneRiseCyc - lastWenCyc, 1);
        chk("nat_w2_addr", wAddrN[mark + 1], 10'd1);
        chk("nat_w3_addr", wAddrN[mark + 2], 10'd2);
        check_ram("steady_ram_image");
        for (int i = 0; i < 5; i++) fifoQ.push_back(32'hDEAD_0000 + 32'(i));
        drive_fifo();
        repeat (20) step();
        chk("no_wrap_ren_count", renCount, N);
        chk("no_wrap_fifo_left", fifoQ.size(), 5);
        chk("done_held", obsDone, 1);
        bus.loadExternal = 1'b0;
        fifoQ.delete();
        drive_fifo();
        step();

        // bursty FIFO with a sequencer model
        pulse_fs();
        seqMode = 1;
        step();
        step();
        chk("slr_at_0", obsSlr, 0);
        for (int i = 0; i < 15; i++) push_frame($urandom);
        step();
        step();
        chk("slr_at_15", obsSlr, 0);
        push_frame($urandom);
        step();
        chk("slr_at_16", obsSlr, 1);
        trickleLeft = N - 16;
        trickleP    = 40;
        wait_done(20000, "bursty_done");
        check_ram("bursty_ram_image");
        seqMode = 0;
        bus.loadExternal = 1'b0;
        step();

        // tail smaller than BURST
        pulse_fs();
        for (int i = 0; i < N - 4; i++) push_frame($urandom);
        bus.loadExternal = 1'b1;
        for (int i = 0; i < 1500 && !(i > 2 && fifoQ.size() == 0 && obsIfe); i++) step();
        bus.loadExternal = 1'b0;
        step();
        step();
        chk("tail_issued", renCount, N - 4);
        for (int i = 0; i < 4; i++) push_frame($urandom);
        step();
        chk("tail_slr", obsSlr, 1);
        mark = wAddr.size();
        bus.loadExternal = 1'b1;
        wait_done(100, "tail_done");
        chk("tail_writes", wAddr.size() - mark, 4);
        check_ram("tail_ram_image");
        bus.loadExternal = 1'b0;
        step();

        // grant drop in the issuing cycle, then random grants to the end
        pulse_fs();
        for (int i = 0; i < 10; i++) push_frame($urandom);
        step();
        step();
        mark = wAddr.size();
        bus.loadExternal = 1'b1;
        step();
        bus.loadExternal = 1'b0;
        repeat (8) step();
        chk("grant_drop_writes", wAddr.size() - mark, 1);
        chk("grant_drop_reads", renCount, 1);
        seqMode     = 1;
        seqDrop     = 1;
        trickleLeft = N - 10;
        trickleP    = 70;
        wait_done(20000, "random_grant_done");
        check_ram("random_grant_ram_image");
        seqMode = 0;
        seqDrop = 0;
        bus.loadExternal = 1'b0;
        step();

        // reset at sample 500, then restart with frame_start and grant together
        pulse_fs();
        bus.loadExternal = 1'b1;
        for (int i = 0; i < N; i++) push_frame($urandom);
        mark = wAddr.size();
        for (int i = 0; i < 2000 && (wAddr.size() - mark) < 500; i++) step();
        rst = 1'b1;
        step();
        step();
        chk("mid_frame_reset_outputs", {bus.fifo_ren, bus.ram_wen, bus.startLoadingRam,
                                        bus.inFifoEmpty, bus.loadExternalDone}, 5'b0);
        rst = 1'b0;
        bus.loadExternal = 1'b0;
        fifoQ.delete();
        popData = '0;
        drive_fifo();
        step();
        step();
        pulse_fs();
        bus.loadExternal = 1'b1;
        for (int i = 0; i < N; i++) begin
            s.re = 16'($urandom);
            s.im = 16'(i);
            push_frame(s);
        end
        mark = wAddr.size();
        wait_done(3000, "restart_done");
        chk("restart_w1_addr", wAddr[mark], 10'h000);
        chk("restart_w1_data", wData[mark], frameSamples[0]);
        check_ram("restart_ram_image");
        bus.loadExternal = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
Upstream neighbour of the FFT sequencer. It drains the input sample FIFO, which the memory controller fills, into the FFT working RAM. Samples are written at bit-reversed addresses so the RAM holds decimation-in-time order when the sequencer starts calculating. It produces the sequencer's load handshake inputs: startLoadingRam, inFifoEmpty and loadExternalDone, and obeys its loadExternal enable.

Parameters:
LOG2N, 10, log2 of FFT points; N = 2**LOG2N samples per frame
SAMPLE_W, 32, complex sample width; real [31:16], imag [15:0], two's complement
CNT_W, 11, FIFO occupancy count width
BURST, 16, minimum FIFO occupancy that requests a load, unless the frame remainder is smaller
BITREV, 1, 1 = bit-reversed RAM write address, 0 = natural order

Ports:
clk  in  1  system clock, all logic posedge
rst  in  1  asynchronous active-high reset
frame_start  in  1  one-cycle pulse (startF|startI accepted); clears counters and arms a new frame
loadExternal  in  1  sequencer grant; reads are issued only while high
fifo_empty  in  1  input FIFO empty flag
fifo_count  in  CNT_W  input FIFO occupancy
fifo_rdata  in  SAMPLE_W  FIFO read data, valid 1 cycle after fifo_ren
fifo_ren  out  1  FIFO pop
ram_wen  out  1  RAM write enable
ram_waddr  out  LOG2N  RAM write address
ram_wdata  out  SAMPLE_W  RAM write data
startLoadingRam  out  1  request to sequencer to (re)enter its load state
inFifoEmpty  out  1  nothing left to move this burst
loadExternalDone  out  1  all N samples of the frame written

Behaviour:
- Reset values: all outputs 0. issued = 0, written = 0, rd_pending = 0. State IDLE. Async rst is honoured mid-frame: the partial frame is discarded and no write occurs in the cycle after reset release.
- States:
  - IDLE -> ARMED on frame_start.
  - ARMED -> FULL when written == N.
  - FULL -> ARMED on frame_start.
- frame_start in any state clears issued and written. Any in-flight read's write still lands (address from the old counter) and is not counted.
- Read issue (ARMED only): fifo_ren = loadExternal & ~fifo_empty & (issued < N). issued increments on each fifo_ren.
- Write: rd_pending <= fifo_ren. When rd_pending is set:
  - ram_wen = 1, ram_wdata = fifo_rdata (combinational, same cycle).
  - ram_waddr = BITREV ? bit-reverse(written[LOG2N-1:0]) : written.
  - written increments.
  - Latency is fixed at 1 cycle from fifo_ren to ram_wen. Throughput is 1 sample/cycle.
- Dropping loadExternal stops new reads only. A read already issued is still written the next cycle.
- inFifoEmpty = ARMED & fifo_empty & ~rd_pending. Also forced 1 when issued == N and ~rd_pending, so the sequencer leaves its load state.
- startLoadingRam = ARMED & ~loadExternal & (issued < N) & ((fifo_count >= BURST) | (fifo_count != 0 & fifo_count >= N - issued)). Comparisons are unsigned at LOG2N+1 bits.
- loadExternalDone is a registered level: set the cycle after the Nth write, held in FULL, cleared by frame_start or rst.
- Write N lands at bit-reversed address N-1 (all ones). No wrap: issued saturates at N, and extra FIFO data stays in the FIFO.
- fifo_empty rising while loadExternal is high stops issue the same cycle. fifo_ren is never asserted when fifo_empty = 1.
- frame_start together with loadExternal: the clear takes priority and no read is issued that cycle.

Decomposition:
- fft_pkg holds shared definitions:
  - FFT_LOG2N, FFT_N and SAMPLE_W constants.
  - typedef struct packed {logic signed [15:0] re, im;} cplx_t.
  - loader_state_t enum {IDLE, ARMED, FULL}.
- One sub-module: bit_reverse (parameter W, combinational, in[W-1:0] -> out[i] = in[W-1-i]). It is shared later with the output unloader.

Test Plan:
- Steady load:
  - Stimulus: frame_start; FIFO preloaded with 1024 samples of value = index; loadExternal held.
  - Required response: 1024 consecutive fifo_ren. Write 1 goes to addr 0x000 with data 0. Write 2 goes to addr 0x200 with data 1. Write 3 goes to addr 0x100 with data 2. loadExternalDone rises 1 cycle after the last ram_wen.
- Bursty FIFO:
  - Stimulus: counts trickle in 0, 15, 16; loadExternal driven by a sequencer model.
  - Required response: startLoadingRam stays 0 at count 15 and goes 1 at count 16. inFifoEmpty = 1 only after the final pending write.
- Tail smaller than BURST:
  - Stimulus: issued = 1020, fifo_count = 4.
  - Required response: startLoadingRam = 1. Exactly 4 more writes, then loadExternalDone.
- Grant drop:
  - Stimulus: deassert loadExternal in the same cycle as fifo_ren is issued.
  - Required response: that one write still occurs next cycle and written increments by exactly 1.
- Reset and restart:
  - Stimulus: rst at sample 500, then frame_start with 1024 new samples.
  - Required response: all outputs 0 during reset. Fresh frame writes start at addr 0x000 and loadExternalDone follows.
- BITREV = 0:
  - Required response: addresses 0, 1, 2, ... natural order.
